// File: rtl/tlut_mvm_engine.sv
// Temporal-LUT matrix-vector engine: y[r] += sum_c x[c]*w[r][c] via a shared ramp,
// with input/output handshakes, multi-tile accumulation and optional early termination.
module tlut_mvm_engine #(
  parameter int unsigned ROWS         = 4,
  parameter int unsigned COLS         = 8,
  parameter int unsigned INPUT_WIDTH  = 8,
  parameter int unsigned WEIGHT_WIDTH = 8,
  parameter int unsigned ACC_WIDTH    = 24,
  parameter int unsigned EARLY_TERM   = 1
) (
  input  logic                                clk,
  input  logic                                rst_n,
  input  logic                                in_valid,
  output logic                                in_ready,
  input  logic                                in_last,
  input  logic [COLS*INPUT_WIDTH-1:0]         in_data,
  input  logic [ROWS*COLS*WEIGHT_WIDTH-1:0]   in_weight,
  output logic                                out_valid,
  input  logic                                out_ready,
  output logic [ROWS*ACC_WIDTH-1:0]           out_data,
  output logic                                busy,
  output logic                                partial
);

  localparam int unsigned SUM_WIDTH = WEIGHT_WIDTH + $clog2(COLS);

  typedef enum logic [1:0] {IDLE, RUN, OUT} state_t;

  state_t                              state_q, state_d;
  logic [COLS*INPUT_WIDTH-1:0]         x_q;
  logic [ROWS*COLS*WEIGHT_WIDTH-1:0]   w_q;
  logic                                last_q;
  logic [INPUT_WIDTH-1:0]              t_q, tmax_q, tmax_in;
  logic [ROWS*ACC_WIDTH-1:0]           acc_q;
  logic signed [SUM_WIDTH-1:0]         row_sum [ROWS];
  logic                                accept, last_step, drain;

  // Ramp length for the offered tile: its largest input, or the full range
  always_comb begin
    tmax_in = '0;
    if (EARLY_TERM != 0) begin
      for (int unsigned c = 0; c < COLS; c++) begin
        if (in_data[c*INPUT_WIDTH +: INPUT_WIDTH] > tmax_in)
          tmax_in = in_data[c*INPUT_WIDTH +: INPUT_WIDTH];
      end
    end else begin
      tmax_in = '1;
    end
  end

  // Per-row sum of weights whose input is still above the ramp
  always_comb begin
    for (int unsigned r = 0; r < ROWS; r++) begin
      row_sum[r] = '0;
      for (int unsigned c = 0; c < COLS; c++) begin
        if (x_q[c*INPUT_WIDTH +: INPUT_WIDTH] > t_q)
          row_sum[r] = row_sum[r]
                     + SUM_WIDTH'($signed(w_q[(r*COLS+c)*WEIGHT_WIDTH +: WEIGHT_WIDTH]));
      end
    end
  end

  always_comb begin
    state_d   = state_q;
    accept    = 1'b0;
    last_step = 1'b0;
    drain     = 1'b0;
    case (state_q)
      IDLE: begin
        if (in_valid) begin
          accept = 1'b1;
          if (tmax_in == '0) state_d = in_last ? OUT : IDLE;
          else               state_d = RUN;
        end
      end
      RUN: begin
        if (t_q == tmax_q - INPUT_WIDTH'(1)) begin
          last_step = 1'b1;
          state_d   = last_q ? OUT : IDLE;
        end
      end
      OUT: begin
        if (out_ready) begin
          drain   = 1'b1;
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // State register and state-decoded handshake flags
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= IDLE;
      in_ready  <= 1'b1;
      out_valid <= 1'b0;
      busy      <= 1'b0;
    end else begin
      state_q   <= state_d;
      in_ready  <= (state_d == IDLE);
      out_valid <= (state_d == OUT);
      busy      <= (state_d != IDLE);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      x_q     <= '0;
      w_q     <= '0;
      last_q  <= 1'b0;
      t_q     <= '0;
      tmax_q  <= '0;
      acc_q   <= '0;
      partial <= 1'b0;
    end else begin
      if (accept) begin
        x_q    <= in_data;
        w_q    <= in_weight;
        last_q <= in_last;
        t_q    <= '0;
        tmax_q <= tmax_in;
        if (tmax_in == '0 && !in_last) partial <= 1'b1;
      end
      if (state_q == RUN) begin
        t_q <= t_q + INPUT_WIDTH'(1);
        for (int unsigned r = 0; r < ROWS; r++)
          acc_q[r*ACC_WIDTH +: ACC_WIDTH] <= acc_q[r*ACC_WIDTH +: ACC_WIDTH]
                                           + ACC_WIDTH'(row_sum[r]);
        if (last_step && !last_q) partial <= 1'b1;
      end
      if (drain) begin
        acc_q   <= '0;
        partial <= 1'b0;
      end
    end
  end

  assign out_data = acc_q;

endmodule

// File: tb/tb_tlut_mvm_engine.sv
// Self-checking bench for tlut_mvm_engine: directed table, corner sequences and
// randomized tiles checked against an arithmetic dot-product model.
module tb_tlut_mvm_engine;
  localparam int ROWS = 4, COLS = 8, IW = 8, WW = 8, AW = 24;

  logic clk = 1'b0;
  logic rst_n, in_valid, in_last, out_ready, in_valid2, out_ready2;
  logic [COLS*IW-1:0]      in_data;
  logic [ROWS*COLS*WW-1:0] in_weight;
  logic in_ready, out_valid, busy, partial;
  logic in_ready2, out_valid2, busy2, partial2;
  logic [ROWS*AW-1:0] out_data, out_data2;

  int checks = 0;
  int errors = 0;
  int xa [COLS];
  int wa [ROWS][COLS];

  typedef struct {
    int x   [COLS];
    int wr  [ROWS];
    int exp [ROWS];
    int lat;
  } vec_t;
  vec_t vecs [5];

  always #5 clk = ~clk;

  tlut_mvm_engine dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready), .in_last(in_last),
    .in_data(in_data), .in_weight(in_weight), .out_valid(out_valid), .out_ready(out_ready),
    .out_data(out_data), .busy(busy), .partial(partial));

  tlut_mvm_engine #(.EARLY_TERM(0)) dut_const (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid2), .in_ready(in_ready2), .in_last(in_last),
    .in_data(in_data), .in_weight(in_weight), .out_valid(out_valid2), .out_ready(out_ready2),
    .out_data(out_data2), .busy(busy2), .partial(partial2));

  task automatic chk(input string name, input longint act, input longint exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s actual=%0d required=%0d", name, act, exp);
    end
  endtask

  function automatic int row(input int r);
    return int'($signed(out_data[r*AW +: AW]));
  endfunction

  function automatic int row2(input int r);
    return int'($signed(out_data2[r*AW +: AW]));
  endfunction

  function automatic int wrap(input longint v);
    logic signed [AW-1:0] t;
    t = AW'(v);
    return int'(t);
  endfunction

  task automatic pack();
    for (int c = 0; c < COLS; c++) in_data[c*IW +: IW] = IW'(xa[c]);
    for (int r = 0; r < ROWS; r++)
      for (int c = 0; c < COLS; c++) in_weight[(r*COLS+c)*WW +: WW] = WW'(wa[r][c]);
  endtask

  task automatic fill(input int xv, input int wv);
    for (int c = 0; c < COLS; c++) xa[c] = xv;
    for (int r = 0; r < ROWS; r++)
      for (int c = 0; c < COLS; c++) wa[r][c] = wv;
  endtask

  task automatic send(input logic last);
    int n = 0;
    @(negedge clk);
    pack();
    in_last  = last;
    in_valid = 1'b1;
    while (!in_ready && n < 1000) begin @(negedge clk); n++; end
    if (!in_ready) chk("send_timeout", 0, 1);
    @(posedge clk);
    #1 in_valid = 1'b0;
  endtask

  task automatic wait_out(output int lat);
    lat = 0;
    @(negedge clk);
    while (!out_valid && lat < 600) begin @(negedge clk); lat++; end
    if (!out_valid) chk("out_timeout", 0, 1);
  endtask

  task automatic handshake(input string name);
    out_ready = 1'b1;
    @(posedge clk);
    #1 out_ready = 1'b0;
    @(negedge clk);
    chk({name, "_in_ready_after_hs"}, in_ready, 1);
    chk({name, "_out_valid_after_hs"}, out_valid, 0);
    chk({name, "_partial_after_hs"}, partial, 0);
  endtask

  task automatic wait_idle(input string name);
    int  n   = 0;
    bit  saw = 1'b0;
    @(negedge clk);
    while (!in_ready && n < 600) begin
      if (out_valid) saw = 1'b1;
      @(negedge clk);
      n++;
    end
    chk({name, "_back_to_idle"}, in_ready, 1);
    chk({name, "_no_out_valid"}, saw | out_valid, 0);
    chk({name, "_partial_set"}, partial, 1);
  endtask

  task automatic reset_checks(input string name);
    chk({name, "_in_ready"}, in_ready, 1);
    chk({name, "_out_valid"}, out_valid, 0);
    chk({name, "_out_data"}, longint'(out_data), 0);
    chk({name, "_busy"}, busy, 0);
    chk({name, "_partial"}, partial, 0);
  endtask

  initial begin
    #5000000;
    $display("FAIL watchdog timeout");
    $fatal(1, "watchdog");
  end

  initial begin
    int     lat, d, m, tmax;
    bit     last;
    longint accm [ROWS];
    int     hold [ROWS];

    rst_n = 1'b0; in_valid = 1'b0; in_valid2 = 1'b0; in_last = 1'b0;
    out_ready = 1'b0; out_ready2 = 1'b0; in_data = '0; in_weight = '0;

    vecs[0].x = '{1,2,3,4,5,6,7,8}; vecs[0].wr = '{1,2,3,4};
    vecs[0].exp = '{36,72,108,144}; vecs[0].lat = 8;
    vecs[1].x = '{255,255,255,255,255,255,255,255}; vecs[1].wr = '{-128,-128,-128,-128};
    vecs[1].exp = '{-261120,-261120,-261120,-261120}; vecs[1].lat = 255;
    vecs[2].x = '{1,1,1,1,1,1,1,1}; vecs[2].wr = '{1,1,1,1};
    vecs[2].exp = '{8,8,8,8}; vecs[2].lat = 1;
    vecs[3].x = '{0,0,0,0,0,0,0,5}; vecs[3].wr = '{-2,-1,0,1};
    vecs[3].exp = '{-10,-5,0,5}; vecs[3].lat = 5;
    vecs[4].x = '{0,0,0,0,0,0,0,0}; vecs[4].wr = '{7,-7,3,-3};
    vecs[4].exp = '{0,0,0,0}; vecs[4].lat = 0;

    repeat (3) @(negedge clk);
    reset_checks("reset_initial");
    rst_n = 1'b1;
    @(negedge clk);
    reset_checks("after_reset");

    // Directed table, all single last tiles
    for (int i = 0; i < 5; i++) begin
      for (int c = 0; c < COLS; c++) xa[c] = vecs[i].x[c];
      for (int r = 0; r < ROWS; r++)
        for (int c = 0; c < COLS; c++) wa[r][c] = vecs[i].wr[r];
      send(1'b1);
      wait_out(lat);
      chk($sformatf("vec%0d_latency", i), lat, vecs[i].lat);
      for (int r = 0; r < ROWS; r++)
        chk($sformatf("vec%0d_row%0d", i, r), row(r), vecs[i].exp[r]);
      handshake($sformatf("vec%0d", i));
    end

    // Constant-latency variant
    for (int c = 0; c < COLS; c++) xa[c] = c + 1;
    for (int r = 0; r < ROWS; r++)
      for (int c = 0; c < COLS; c++) wa[r][c] = r + 1;
    @(negedge clk);
    pack(); in_last = 1'b1; in_valid2 = 1'b1;
    @(posedge clk);
    #1 in_valid2 = 1'b0;
    lat = 0;
    @(negedge clk);
    while (!out_valid2 && lat < 600) begin @(negedge clk); lat++; end
    chk("const_latency", lat, 255);
    for (int r = 0; r < ROWS; r++) chk($sformatf("const_row%0d", r), row2(r), 36*(r+1));
    out_ready2 = 1'b1;
    @(posedge clk);
    #1 out_ready2 = 1'b0;
    @(negedge clk);
    chk("const_in_ready_after_hs", in_ready2, 1);

    // Two-tile accumulation
    fill(1, 2);
    send(1'b0);
    wait_idle("tileA");
    fill(3, -1);
    send(1'b1);
    wait_out(lat);
    chk("tileB_latency", lat, 3);
    for (int r = 0; r < ROWS; r++) chk($sformatf("tileAB_row%0d", r), row(r), -8);
    chk("tileB_partial_before_hs", partial, 1);
    handshake("tileAB");

    // Zero input with backpressure and ignored in_valid
    fill(0, 9);
    send(1'b1);
    wait_out(lat);
    chk("zero_latency", lat, 0);
    chk("zero_data", longint'(out_data), 0);
    for (int i = 0; i < 5; i++) begin
      fill(int'($urandom_range(1, 255)), 5);
      pack(); in_last = 1'b0; in_valid = 1'b1;
      @(negedge clk);
      chk($sformatf("bp%0d_out_data_stable", i), longint'(out_data), 0);
      chk($sformatf("bp%0d_in_ready_low", i), in_ready, 0);
      chk($sformatf("bp%0d_out_valid_held", i), out_valid, 1);
    end
    in_valid = 1'b0;
    handshake("bp");
    chk("bp_busy_after_hs", busy, 0);

    // Reset mid-RUN discards the running tile
    fill(200, 1);
    send(1'b1);
    repeat (50) @(negedge clk);
    chk("midrun_busy", busy, 1);
    rst_n = 1'b0;
    #1 reset_checks("midrun_during_reset");
    repeat (3) @(negedge clk);
    reset_checks("midrun_reset_held");
    rst_n = 1'b1;
    @(negedge clk);
    reset_checks("midrun_after_reset");
    fill(1, 1);
    send(1'b1);
    wait_out(lat);
    chk("post_reset_latency", lat, 1);
    for (int r = 0; r < ROWS; r++) chk($sformatf("post_reset_row%0d", r), row(r), 8);
    handshake("post_reset");

    // Randomized tiles against the arithmetic model
    for (int r = 0; r < ROWS; r++) accm[r] = 0;
    for (int i = 0; i < 30; i++) begin
      m = int'($urandom_range(0, 255));
      tmax = 0;
      for (int c = 0; c < COLS; c++) begin
        xa[c] = int'($urandom_range(0, m));
        if (xa[c] > tmax) tmax = xa[c];
      end
      for (int r = 0; r < ROWS; r++)
        for (int c = 0; c < COLS; c++) begin
          wa[r][c] = int'($urandom_range(0, 255)) - 128;
          accm[r] += longint'(xa[c]) * longint'(wa[r][c]);
        end
      last = ($urandom_range(0, 2) == 0) || (i == 29);
      send(last);
      if (last) begin
        wait_out(lat);
        chk($sformatf("rnd%0d_latency", i), lat, tmax);
        for (int r = 0; r < ROWS; r++) hold[r] = wrap(accm[r]);
        d = int'($urandom_range(0, 3));
        for (int k = 0; k < d; k++) @(negedge clk);
        for (int r = 0; r < ROWS; r++)
          chk($sformatf("rnd%0d_row%0d", i, r), row(r), hold[r]);
        handshake($sformatf("rnd%0d", i));
        for (int r = 0; r < ROWS; r++) accm[r] = 0;
      end else begin
        wait_idle($sformatf("rnd%0d", i));
      end
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
